// File: rtl/mips_cpu_multiplier.sv
// Iterative shift-add MULT/MULTU: one partial-product step per cycle, 64-bit product into Hi/Lo.
// Latency 32 cycles from start (1 cycle for a zero operand); a new start aborts any operation in flight.
module mips_cpu_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] Multiplicand,
  input  logic [WIDTH-1:0] Multiplier,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   m;
  logic [CW-1:0]      i;
  logic               sign;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     upper;
  logic [2*WIDTH-1:0] p_next;
  logic [2*WIDTH-1:0] result;

  // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    a_mag  = (is_signed && Multiplicand[WIDTH-1]) ? -Multiplicand : Multiplicand;
    b_mag  = (is_signed && Multiplier[WIDTH-1])   ? -Multiplier   : Multiplier;
    upper  = p[0] ? ({1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m}) : {1'b0, p[2*WIDTH-1:WIDTH]};
    p_next = {upper, p[WIDTH-1:1]};
    result = sign ? -p_next : p_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      p     <= '0;
      m     <= '0;
      i     <= '0;
      sign  <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      done <= 1'b0;
      i    <= '0;
      sign <= is_signed & (Multiplicand[WIDTH-1] ^ Multiplier[WIDTH-1]);
      if (Multiplicand == '0 || Multiplier == '0) begin
        state <= FINISH;
        busy  <= 1'b0;
      end else begin
        state <= RUN;
        p     <= {{WIDTH{1'b0}}, b_mag};
        m     <= a_mag;
        busy  <= 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          p <= p_next;
          i <= i + CW'(1);
          if (i == CW'(WIDTH - 1)) begin
            {Hi, Lo} <= result;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        FINISH: begin
          Hi    <= '0;
          Lo    <= '0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
